mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-ported instruction/data SRAM between the fetch stage (read-only) and the memory stage (read/write). Grants one access at a time, holds the SRAM for a fixed number of wait cycles and returns read data through registered per-requester outputs. Drives the pipeline `freeze` while any request is outstanding. Sits between the fetch/memory stages and the SRAM model.

## Interface
Parameters:
- `ADDRESS_LEN`, 32, address width (from `configs.v`)
- `DATA_LEN`, 32, data width
- `WAIT_CYCLES`, 3, SRAM busy cycles per access; must be at least 1

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `if_req`  in  1  fetch read request; held until `if_ready`
- `if_addr`  in  ADDRESS_LEN  fetch address
- `if_rdata`  out  DATA_LEN  fetched instruction; registered
- `if_ready`  out  1  one-cycle completion pulse for fetch
- `mem_rd_en`, `mem_wr_en`  in  1 each  memory-stage read and write requests; held until `mem_ready`
- `mem_addr`  in  ADDRESS_LEN  data address
- `mem_wdata`  in  DATA_LEN  write data
- `mem_rdata`  out  DATA_LEN  read data; registered
- `mem_ready`  out  1  one-cycle completion pulse for the memory stage
- `freeze`  out  1  pipeline stall
- `sram_en`, `sram_we`  out  1 each  SRAM enable and write strobe
- `sram_addr`  out  ADDRESS_LEN  SRAM address
- `sram_wdata`  out  DATA_LEN  SRAM write data
- `sram_rdata`  in  DATA_LEN  SRAM read data; valid during the last busy cycle

## Operation
- The FSM has three states: IDLE, BUSY and RESP.
- **IDLE:**
  - If no request is pending, stay in IDLE.
  - If exactly one requester is pending, grant it.
  - If both are pending, grant the requester not named by `last_grant`. `last_grant` resets to IF, so the memory stage wins the first tie.
  - On a grant: latch address, write data, write flag and grant owner; load `cnt` with WAIT_CYCLES-1; go to BUSY; update `last_grant`.
- `mem_rd_en` and `mem_wr_en` both high is treated as a write.
- **BUSY:**
  - `sram_en` is 1.
  - `sram_addr`, `sram_we` and `sram_wdata` come from the latched values and are stable for the whole access.
  - `cnt` decrements each cycle.
  - When `cnt` is 0: on a read, capture `sram_rdata` into the owner's rdata register; go to RESP.
- **RESP:** assert the owner's ready for one cycle; ignore requests; go to IDLE.
- `if_rdata` and `mem_rdata` hold their value until the next completed read by the same requester. A write leaves `mem_rdata` unchanged.
- `freeze = (if_req & ~if_ready) | ((mem_rd_en | mem_wr_en) & ~mem_ready)`. This is combinational.
- A request dropped mid-access is not aborted. The access completes and the ready pulse is still issued.
- Reset (`rst` low) takes effect asynchronously at any point, including mid-access:
  - state goes to IDLE; `last_grant` goes to IF;
  - all outputs and registers go to 0, so `sram_en`, `sram_we`, both ready signals and both rdata registers are 0;
  - `freeze` follows its equation from the request inputs.

## Timing
- A request sampled in IDLE at edge t gives:
  - BUSY during cycles t+1 .. t+WAIT_CYCLES;
  - RESP (ready = 1, rdata valid) in cycle t+WAIT_CYCLES+1;
  - IDLE in cycle t+WAIT_CYCLES+2.
- Access latency is WAIT_CYCLES+1 cycles from grant to ready. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- With WAIT_CYCLES=1: one BUSY cycle, ready at t+2.
- A request held through RESP is re-arbitrated in the following IDLE cycle. No request is ever served twice within a single RESP.
- Outputs are registered except `freeze`.

## Structure
- `ADDRESS_LEN` and `DATA_LEN` come from `configs.v`.
- State encoding is local parameters inside the module.
- One sub-module, `mem_wait_counter`: loadable down-counter with `load`, `load_value` and a `zero` flag, async active-low reset; width is $clog2(WAIT_CYCLES)+1.
- The FSM, grant latch and rdata registers stay in the top module.

## Test plan
- **Reset:** `rst`=0 mid-BUSY -> `sram_en`=0, both ready=0, both rdata=0 immediately; after release, state is IDLE.
- **Single fetch (WAIT_CYCLES=3):** `if_req`=1, `if_addr`=0x10, SRAM returns 0xE3A01005 -> `sram_en` high for 3 cycles, `if_ready` pulses at cycle t+4, `if_rdata`=0xE3A01005, `freeze` high for cycles t..t+3.
- **Contention from reset:** `if_req` and `mem_rd_en` rise together -> memory stage served first (`mem_ready` at t+4), fetch granted at t+5 (`if_ready` at t+9).
- **Round-robin:** both held continuously -> grants alternate MEM, IF, MEM, IF; neither requester waits more than 2 accesses.
- **Write:** `mem_wr_en`=1, addr 0x400, data 0xDEADBEEF -> `sram_we`=1 with stable address/data for 3 cycles; `mem_ready` pulses; `mem_rdata` unchanged.
- **Withdrawn request:** `if_req` dropped one cycle after grant -> access completes, `if_ready` still pulses at t+4, next cycle IDLE with no new grant.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and grant encoding for the fetch/memory SRAM arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Owner of the current (or most recent) SRAM access.
    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times SRAM busy cycles; holds at zero.
module mem_wait_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    // Load has priority over decrement; never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported SRAM between fetch (read) and memory stage (read/write).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDRESS_LEN = ADDR_W,
    parameter int unsigned DATA_LEN    = DATA_W,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [ADDRESS_LEN-1:0] if_addr,
    output logic [DATA_LEN-1:0]    if_rdata,
    output logic                   if_ready,
    input  logic                   mem_rd_en,
    input  logic                   mem_wr_en,
    input  logic [ADDRESS_LEN-1:0] mem_addr,
    input  logic [DATA_LEN-1:0]    mem_wdata,
    output logic [DATA_LEN-1:0]    mem_rdata,
    output logic                   mem_ready,
    output logic                   freeze,
    output logic                   sram_en,
    output logic                   sram_we,
    output logic [ADDRESS_LEN-1:0] sram_addr,
    output logic [DATA_LEN-1:0]    sram_wdata,
    input  logic [DATA_LEN-1:0]    sram_rdata
);

    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    grant_e               owner_q, owner_c, last_grant_q;
    logic                 grant_c, done_c, cnt_en_c, cnt_zero, mem_req_c;
    logic [ADDRESS_LEN-1:0] addr_q;
    logic [DATA_LEN-1:0]  wdata_q, if_rdata_q, mem_rdata_q;
    logic                 sram_en_q, sram_we_q, if_ready_q, mem_ready_q;

    assign mem_req_c = mem_rd_en | mem_wr_en;

    mem_wait_counter #(
        .WIDTH(CNT_W)
    ) u_wait_counter (
        .clk        (clk),
        .rst_n      (rst),
        .load       (grant_c),
        .en         (cnt_en_c),
        .load_value (CNT_W'(WAIT_CYCLES - 1)),
        .zero       (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant selection and counter control.
    always_comb begin
        state_d  = state_q;
        grant_c  = 1'b0;
        done_c   = 1'b0;
        cnt_en_c = 1'b0;
        owner_c  = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (if_req || mem_req_c) begin
                    grant_c = 1'b1;
                    state_d = S_BUSY;
                    if (if_req && mem_req_c) begin
                        owner_c = (last_grant_q == GNT_IF) ? GNT_MEM : GNT_IF;
                    end else if (mem_req_c) begin
                        owner_c = GNT_MEM;
                    end else begin
                        owner_c = GNT_IF;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_zero) begin
                    done_c  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_en_c = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Grant latch, SRAM drive registers, read-data capture and ready pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= GNT_IF;
            last_grant_q <= GNT_IF;
            addr_q       <= '0;
            wdata_q      <= '0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
        end else begin
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if (grant_c) begin
                owner_q      <= owner_c;
                last_grant_q <= owner_c;
                sram_en_q    <= 1'b1;
                if (owner_c == GNT_MEM) begin
                    addr_q    <= mem_addr;
                    wdata_q   <= mem_wdata;
                    sram_we_q <= mem_wr_en;
                end else begin
                    addr_q    <= if_addr;
                    wdata_q   <= '0;
                    sram_we_q <= 1'b0;
                end
            end
            if (done_c) begin
                sram_en_q <= 1'b0;
                sram_we_q <= 1'b0;
                if (owner_q == GNT_IF) begin
                    if_ready_q <= 1'b1;
                    if (!sram_we_q) begin
                        if_rdata_q <= sram_rdata;
                    end
                end else begin
                    mem_ready_q <= 1'b1;
                    if (!sram_we_q) begin
                        mem_rdata_q <= sram_rdata;
                    end
                end
            end
        end
    end

    assign sram_en    = sram_en_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign if_ready   = if_ready_q;
    assign mem_ready  = mem_ready_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;

    // Stall the pipeline while any request is still waiting for its ready.
    assign freeze = (if_req & ~if_ready_q) | (mem_req_c & ~mem_ready_q);

endmodule
